alu_operand_stager: RTL and testbench

- Sequencing stage directly upstream of the 16-bit bitwise logic unit (the and16 instance) in the ALU datapath.
- Accepts operand A and then operand B, one word per handshake, over a shared input bus.
- Registers both operands and drives them steady onto the logic unit inputs.
- Waits a fixed settle time, then captures the unit's result and holds it with a valid/ready handshake until the consumer takes it.

---
 rtl/alu_operand_stager.sv | 134 +++++++++++++
 tb/tb_alu_operand_stager.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stager.sv
// rtl/alu_operand_stager.sv - operand sequencer and result holder in front of the and16 logic unit
//
// Purpose: takes operand A then operand B over one shared handshaked bus,
// drives them steady onto the logic unit, waits SETTLE cycles, captures the
// unit output and holds it on a valid/ready handshake until consumed.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   bus_in     operand word (A first, then B)
//   bus_valid  bus_in holds a word
//   bus_ready  stager accepts a word this cycle (LOAD_A / LOAD_B only)
//   op_a       registered operand A to logic unit in1
//   op_b       registered operand B to logic unit in2
//   res_in     logic unit output
//   res_out    captured result
//   res_valid  res_out holds an unconsumed result
//   res_ready  consumer takes res_out this cycle
//   busy       high in every state except LOAD_A
//   op_count   completed result transfers, wraps modulo 2^CNT_W
module alu_operand_stager #(
  parameter int WIDTH  = 16,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] bus_in,
  input  logic             bus_valid,
  output logic             bus_ready,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] res_in,
  output logic [WIDTH-1:0] res_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  generate
    if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
      $error("alu_operand_stager: SETTLE must be in 1..15");
    end
  endgenerate

  localparam logic [1:0] S_LOAD_A = 2'd0;
  localparam logic [1:0] S_LOAD_B = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  // The counter is loaded with SETTLE on the B transfer and captures when it
  // reaches zero, so the capture edge lands SETTLE+1 edges after operand B.
  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE);

  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Ready depends on state alone, never on bus_valid.
  assign bus_ready = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
  assign busy      = (state_q != S_LOAD_A);
  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign res_out   = res_q;
  assign res_valid = valid_q;
  assign op_count  = count_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    res_d   = res_q;
    valid_d = valid_q;
    count_d = count_q;
    case (state_q)
      S_LOAD_A: begin
        if (bus_valid) begin
          op_a_d  = bus_in;
          state_d = S_LOAD_B;
        end
      end
      S_LOAD_B: begin
        if (bus_valid) begin
          op_b_d  = bus_in;
          cnt_d   = SETTLE_INIT;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == 4'd0) begin
          res_d   = res_in;
          valid_d = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        if (res_ready) begin
          valid_d = 1'b0;
          count_d = count_q + CNT_W'(1);
          state_d = S_LOAD_A;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_LOAD_A;
      cnt_q   <= 4'd0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      res_q   <= res_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_alu_operand_stager.sv
// tb/tb_alu_operand_stager.sv - scoreboard bench for alu_operand_stager
module tb_alu_operand_stager;

  logic        clk = 1'b0;
  logic        rst       [2];
  logic [15:0] bus_in    [2];
  logic        bus_valid [2];
  logic        bus_ready [2];
  logic [15:0] op_a      [2];
  logic [15:0] op_b      [2];
  logic [15:0] res_in    [2];
  logic [15:0] res_out   [2];
  logic        res_valid [2];
  logic        res_ready [2];
  logic        busy      [2];
  logic        glitch    [2];
  logic [15:0] junk      [2];
  logic [7:0]  cnt0;
  logic [1:0]  cnt1;

  always #5 clk = ~clk;

  // Instance 0: defaults. Instance 1: SETTLE=3, CNT_W=2.
  alu_operand_stager u_dut0 (
    .clk(clk), .rst(rst[0]), .bus_in(bus_in[0]), .bus_valid(bus_valid[0]),
    .bus_ready(bus_ready[0]), .op_a(op_a[0]), .op_b(op_b[0]), .res_in(res_in[0]),
    .res_out(res_out[0]), .res_valid(res_valid[0]), .res_ready(res_ready[0]),
    .busy(busy[0]), .op_count(cnt0)
  );

  alu_operand_stager #(.WIDTH(16), .SETTLE(3), .CNT_W(2)) u_dut1 (
    .clk(clk), .rst(rst[1]), .bus_in(bus_in[1]), .bus_valid(bus_valid[1]),
    .bus_ready(bus_ready[1]), .op_a(op_a[1]), .op_b(op_b[1]), .res_in(res_in[1]),
    .res_out(res_out[1]), .res_valid(res_valid[1]), .res_ready(res_ready[1]),
    .busy(busy[1]), .op_count(cnt1)
  );

  // Stand-in for the and16 unit; glitch drives garbage to prove res_in is
  // only sampled during the settle window.
  assign res_in[0] = glitch[0] ? junk[0] : (op_a[0] & op_b[0]);
  assign res_in[1] = glitch[1] ? junk[1] : (op_a[1] & op_b[1]);

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  localparam int SETTLE_OF [2] = '{1, 3};
  localparam int CNT_MOD   [2] = '{256, 4};

  // Reference model state
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  bit          armed    [2] = '{0, 0};
  bit          have_a   [2];
  bit          inflight [2];
  bit          prev_v   [2];
  logic [15:0] m_a      [2];
  logic [15:0] m_b      [2];
  logic [15:0] m_res    [2];
  int          m_cnt    [2];
  int          b_edge   [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, int k, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[dut%0d] cyc=%0d: got %h expected %h", name, k, cyc, act, exp);
    end
  endtask

  function automatic int qsize(int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [15:0] qpop(int k);
    if (k == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  function automatic logic [15:0] qfront(int k);
    if (k == 0) return q0[0];
    return q1[0];
  endfunction

  task automatic qpush(int k, logic [15:0] v);
    if (k == 0) q0.push_back(v);
    else q1.push_back(v);
  endtask

  // Monitor: runs on the falling edge, checks outputs against the model and
  // advances the model for whatever transfers the next rising edge performs.
  task automatic mon(int k);
    int          cntv;
    bit          exp_valid;
    logic [15:0] popped;
    cntv = (k == 0) ? int'(cnt0) : int'(cnt1);
    if (rst[k]) begin
      have_a[k] = 0; inflight[k] = 0; prev_v[k] = 0;
      m_a[k] = '0; m_b[k] = '0; m_res[k] = '0; m_cnt[k] = 0;
      if (k == 0) q0.delete(); else q1.delete();
      armed[k] = 1;
      return;
    end
    if (!armed[k]) return;
    exp_valid = inflight[k] && ((cyc - b_edge[k]) > SETTLE_OF[k]);
    check("bus_ready", k, 32'(bus_ready[k]), 32'(!inflight[k]));
    check("busy", k, 32'(busy[k]), 32'(have_a[k] || inflight[k]));
    check("op_count", k, cntv, m_cnt[k]);
    check("op_a", k, 32'(op_a[k]), 32'(m_a[k]));
    check("op_b", k, 32'(op_b[k]), 32'(m_b[k]));
    check("res_valid", k, 32'(res_valid[k]), 32'(exp_valid));
    if (res_valid[k] && !prev_v[k]) begin
      if (qsize(k) == 0) begin
        n_checks++; n_fail++;
        $display("FAIL spurious_result[dut%0d] cyc=%0d: got res_valid=1 expected no pending result", k, cyc);
      end else begin
        m_res[k] = qfront(k);
        check("latency", k, cyc - b_edge[k], SETTLE_OF[k] + 1);
      end
    end
    check("res_out", k, 32'(res_out[k]), 32'(m_res[k]));
    if (bus_valid[k] && bus_ready[k]) begin
      if (!have_a[k]) begin
        m_a[k] = bus_in[k];
        have_a[k] = 1;
      end else begin
        m_b[k] = bus_in[k];
        qpush(k, m_a[k] & bus_in[k]);
        have_a[k] = 0;
        inflight[k] = 1;
        b_edge[k] = cyc + 1;
      end
    end
    if (res_valid[k] && res_ready[k] && qsize(k) > 0) begin
      popped = qpop(k);
      check("result", k, 32'(res_out[k]), 32'(popped));
      m_cnt[k] = (m_cnt[k] + 1) % CNT_MOD[k];
      inflight[k] = 0;
    end
    prev_v[k] = res_valid[k];
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) mon(k);
  end

  // Drivers: all called just after a rising edge.
  task automatic idle(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_word(int k, logic [15:0] w);
    bit ok;
    ok = 0;
    bus_in[k] = w;
    bus_valid[k] = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus_ready[k]) begin ok = 1; break; end
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL word_timeout[dut%0d]: got no bus_ready in 200 cycles expected ready", k);
    end
    @(posedge clk); #1;
    bus_valid[k] = 1'b0;
    bus_in[k] = 16'($urandom);
  endtask

  task automatic take_result(int k, bit rnd);
    for (int i = 0; i < 300; i++) begin
      res_ready[k] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (res_valid[k] && res_ready[k]) begin
        @(posedge clk); #1;
        res_ready[k] = 1'b1;
        return;
      end
      @(posedge clk); #1;
    end
    n_checks++; n_fail++;
    $display("FAIL result_timeout[dut%0d]: got no result transfer in 300 cycles expected one", k);
    res_ready[k] = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; bus_in[k] = '0; bus_valid[k] = 1'b0;
      res_ready[k] = 1'b1; glitch[k] = 1'b0; junk[k] = '0;
    end
    idle(3);
    rst[0] = 1'b0; rst[1] = 1'b0;
    idle(2);

    // Basic AND
    send_word(0, 16'hAAAA);
    send_word(0, 16'hAAA5);
    take_result(0, 0);
    idle(2);

    // Back-pressure with a stray word and a noisy res_in
    res_ready[0] = 1'b0;
    send_word(0, 16'hFFFF);
    send_word(0, 16'h1234);
    idle(3);
    bus_in[0] = 16'hDEAD; bus_valid[0] = 1'b1; glitch[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin junk[0] = 16'($urandom); idle(1); end
    bus_valid[0] = 1'b0; res_ready[0] = 1'b1;
    idle(1);
    glitch[0] = 1'b0;
    idle(2);

    // Gapped loads
    send_word(0, 16'h0F0F);
    idle(2);
    send_word(0, 16'h00FF);
    take_result(0, 0);
    idle(2);

    // Reset while in SETTLE
    res_ready[0] = 1'b1;
    send_word(0, 16'h5555);
    send_word(0, 16'h5555);
    rst[0] = 1'b1;
    idle(1);
    rst[0] = 1'b0;
    idle(6);

    // Counter wrap and long settle on instance 1
    res_ready[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send_word(1, 16'($urandom));
      send_word(1, 16'($urandom));
    end
    idle(8);

    // Randomized traffic on both instances
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 25; i++) begin
        send_word(k, 16'($urandom));
        idle($urandom_range(0, 2));
        send_word(k, 16'($urandom));
        take_result(k, 1);
        idle($urandom_range(0, 1));
      end
    end

    // Random-position reset on instance 1
    send_word(1, 16'($urandom));
    send_word(1, 16'($urandom));
    idle($urandom_range(0, 3));
    rst[1] = 1'b1;
    idle(1);
    rst[1] = 1'b0;
    idle(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
